speed_tick_ctrl: RTL

- Parametrised, single-clock successor to the clock-mux speed controller.
- Produces speed selection as a clock-enable tick from one clock, so there is no clock muxing and no BUFG.
- Switch inputs are synchronised and debounced. Speed changes apply only at period boundaries, so the tick is glitch-free.
- A configurable up/down/hold counter drives the LED bar from its top bits.

---
 rtl/speed_tick_ctrl_if.sv | 24 ++
 rtl/speed_tick_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/speed_tick_ctrl_if.sv
// speed_tick_ctrl_if: switch/control inputs and tick/status outputs of the
// single-clock speed controller.
//   sw        : raw speed-select switches (asynchronous)
//   dir       : count direction, 0 = up, 1 = down
//   hold      : freeze the speed counter while high
//   tick      : one-cycle enable pulse at the selected rate
//   led       : top LED_W bits of the speed counter
//   speed_idx : speed index currently in effect
//   pending   : an accepted speed change is waiting for the period boundary
interface speed_tick_ctrl_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned LED_W = 4
) ();
  logic [SEL_W-1:0] sw;
  logic             dir;
  logic             hold;
  logic             tick;
  logic [LED_W-1:0] led;
  logic [SEL_W-1:0] speed_idx;
  logic             pending;

  modport master (output sw, dir, hold, input tick, led, speed_idx, pending);
  modport slave  (input sw, dir, hold, output tick, led, speed_idx, pending);
endinterface

// File: rtl/speed_tick_ctrl.sv
// speed_tick_ctrl: speed selection as a clock-enable tick from one clock.
// Switches are synchronised and debounced; a new speed takes effect only at
// the end of the running period so the tick never produces a runt period.
// An up/down/hold counter advanced by the tick drives the LED bar.
//   clk_100mhz : sole clock
//   rst        : synchronous active-high reset
//   bus        : slave side of speed_tick_ctrl_if (sw/dir/hold in,
//                tick/led/speed_idx/pending out)
module speed_tick_ctrl #(
  parameter int unsigned NUM_SPEEDS = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 8,
  parameter logic [NUM_SPEEDS*DIV_W-1:0] DIV_TABLE = {8'd1, 8'd2, 8'd20, 8'd0},
  parameter int unsigned CNT_W = 27,
  parameter int unsigned LED_W = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  speed_tick_ctrl_if.slave bus
);

  localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Divider table lookup; indices with no table entry read as stopped.
  function automatic logic [DIV_W-1:0] div_of(input logic [SEL_W-1:0] idx);
    logic [DIV_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NUM_SPEEDS; i++) begin
      if (idx == SEL_W'(i)) d = DIV_TABLE[i*DIV_W +: DIV_W];
    end
    return d;
  endfunction

  logic [SEL_W-1:0] r_sync1;
  logic [SEL_W-1:0] r_sync2;
  logic [SEL_W-1:0] r_sw_stable;
  logic [DBC_W-1:0] r_dbc;

  state_t           r_state;
  logic [DIV_W-1:0] r_presc;
  logic [SEL_W-1:0] r_idx;
  logic             r_pend;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_presc_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic             w_pend_nxt;
  logic [DIV_W-1:0] w_div_act;
  logic [DIV_W-1:0] w_div_new;
  logic             w_tick;

  // Two-flop synchroniser followed by the debounce counter.
  // r_sync1 is the value r_sync2 takes next; a disagreement means the switch
  // is still moving, so the stability count restarts.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sw_stable <= '0;
      r_dbc       <= '0;
    end else begin
      r_sync1 <= bus.sw;
      r_sync2 <= r_sync1;
      if ((r_sync2 == r_sw_stable) || (r_sync1 != r_sync2)) begin
        r_dbc <= '0;
      end else if (r_dbc == DBC_LAST) begin
        r_sw_stable <= r_sync2;
        r_dbc       <= '0;
      end else begin
        r_dbc <= r_dbc + DBC_W'(1);
      end
    end
  end

  assign w_div_act = div_of(r_idx);
  assign w_div_new = div_of(r_sw_stable);
  // Tick is a pure decode of registered state.
  assign w_tick    = (r_state != ST_STOPPED) && (r_presc == (w_div_act - DIV_W'(1)));

  // Speed FSM state register.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state <= ST_STOPPED;
      r_presc <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Speed FSM next state; a change commits only on the old rate's tick.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_STOPPED: begin
        w_presc_nxt = '0;
        if (r_sw_stable != r_idx) begin
          w_idx_nxt = r_sw_stable;
          if (w_div_new != '0) w_state_nxt = ST_RUN;
        end else if (w_div_act != '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + DIV_W'(1);
        if (r_sw_stable != r_idx) begin
          w_state_nxt = ST_PENDING;
          w_pend_nxt  = 1'b1;
        end
      end
      ST_PENDING: begin
        w_presc_nxt = w_tick ? '0 : r_presc + DIV_W'(1);
        if (r_sw_stable == r_idx) begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = 1'b0;
        end else if (w_tick) begin
          w_idx_nxt   = r_sw_stable;
          w_presc_nxt = '0;
          w_pend_nxt  = 1'b0;
          w_state_nxt = (w_div_new != '0) ? ST_RUN : ST_STOPPED;
        end
      end
      default: begin
        w_state_nxt = ST_STOPPED;
        w_presc_nxt = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Speed counter: wraps modulo 2**CNT_W, frozen by hold, kept across speed changes.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick && !bus.hold) begin
      r_cnt <= bus.dir ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
    end
  end

  assign bus.tick      = w_tick;
  assign bus.led       = r_cnt[CNT_W-1 -: LED_W];
  assign bus.speed_idx = r_idx;
  assign bus.pending   = r_pend;

endmodule
